// File: rtl/disp_scan_pkg.sv
// ---------------------------------------------------------------------------
// disp_scan_pkg
// Shared constants for the multiplexed 7-segment display driver:
//   - active-low segment glyphs {g,f,e,d,c,b,a}
//   - all-anodes-off code
//   - 2-bit scan state encoding and the anode code for each state
// ---------------------------------------------------------------------------
package disp_scan_pkg;

  // Decimal glyphs, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;

  // Hex letters and the invalid-BCD dash
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Scan states, one per display digit
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } scan_state_e;

  // One-hot-low anode enable for the digit owned by a scan state
  function automatic logic [3:0] anCode(input scan_state_e st);
    logic [3:0] code;
    case (st)
      S0:      code = 4'b1110;
      S1:      code = 4'b1101;
      S2:      code = 4'b1011;
      default: code = 4'b0111;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/disp_scan_seg7_dec.sv
// ---------------------------------------------------------------------------
// seg7_dec
// Combinational 4-bit to 7-segment decoder (active-low {g,f,e,d,c,b,a}).
// Build option: DISP_HEX_EN
//   defined   -> codes 10..15 render as A, b, C, d, E, F
//   undefined -> codes 10..15 render as a dash to flag an invalid BCD value
// Ports:
//   nibble_i  4-bit value to display
//   seg_o     segment pattern, active-low
// ---------------------------------------------------------------------------
module seg7_dec
  import disp_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Anything not explicitly decoded falls back to the dash glyph
  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
`ifdef DISP_HEX_EN
      4'd10: seg_o = SEG_A;
      4'd11: seg_o = SEG_B;
      4'd12: seg_o = SEG_C;
      4'd13: seg_o = SEG_D;
      4'd14: seg_o = SEG_E;
      4'd15: seg_o = SEG_F;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// ---------------------------------------------------------------------------
// disp_scan
// Four-digit multiplexed 7-segment driver for a common-anode display.
// Captures two result nibbles and two carry flags on LOAD and scans them
// out as digits 0..3 (B, Cout0, C, Cout1). AN and SEG are registered; the
// first GUARD cycles of each digit slot keep all anodes off to avoid ghosting.
// Build option: DISP_HEX_EN (hex glyphs for codes 10..15, see seg7_dec).
// Parameters:
//   DIV_W   prescaler width, one scan step every 2^DIV_W cycles (>= 2)
//   GUARD   anodes-off cycles at the start of each slot (< 2^DIV_W)
// Ports:
//   CLK     system clock
//   RST     synchronous active-high reset
//   LOAD    capture strobe for B, C, Cout0, Cout1
//   B, C    result nibbles shown on digits 0 and 2
//   Cout0/1 carry flags shown on digits 1 and 3
//   BLANK   forces all anodes off while high (scan keeps running)
//   AN      anode enables, active-low
//   SEG     segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned GUARD = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic       Cout0,
  input  logic       Cout1,
  input  logic       BLANK,
  output logic [3:0] AN,
  output logic [6:0] SEG
);

  localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);

  logic [3:0]       capB_q, capC_q;
  logic             capCout0_q, capCout1_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             tick;
  logic [3:0]       selNibble;
  logic [6:0]       decSeg;

  // Next-state logic. The output codes are computed from the current
  // (pre-edge) counter and state, so a new slot shows its guard interval
  // for cnt = 0 .. GUARD-1 right after the tick edge.
  always_comb begin
    tick    = &cnt_q;
    cnt_d   = cnt_q + 1'b1;
    state_d = state_q;
    if (tick) begin
      state_d = scan_state_e'(state_q + 2'd1);
    end

    selNibble = 4'd0;
    case (state_q)
      S0:      selNibble = capB_q;
      S1:      selNibble = {3'b000, capCout0_q};
      S2:      selNibble = capC_q;
      default: selNibble = {3'b000, capCout1_q};
    endcase

    an_d = anCode(state_q);
    if (BLANK || (cnt_q < GUARD_CNT)) begin
      an_d = AN_OFF;
    end
    seg_d = decSeg;
  end

  seg7_dec u_dec (
    .nibble_i (selNibble),
    .seg_o    (decSeg)
  );

  // Scan FSM with registered outputs and the input capture registers.
  // Capture and tick share the same edge, so a LOAD on a tick edge is
  // already visible when the new digit comes out of its guard interval.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      state_q    <= S0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      capB_q     <= 4'd0;
      capC_q     <= 4'd0;
      capCout0_q <= 1'b0;
      capCout1_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (LOAD) begin
        capB_q     <= B;
        capC_q     <= C;
        capCout0_q <= Cout0;
        capCout1_q <= Cout1;
      end
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_disp_scan
// Self-checking bench for disp_scan with DIV_W=4, GUARD=2. A frame-time
// model predicts AN/SEG every cycle from the number of edges since reset;
// directed scenarios pin the model with literal expectations, followed by
// randomized LOAD/BLANK/RST traffic.
// ---------------------------------------------------------------------------
module tb_disp_scan;

  localparam int DIV_W   = 4;
  localparam int GUARD   = 2;
  localparam int SLOT    = 1 << DIV_W;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD = 1'b0;
  logic [3:0] B = 4'd0;
  logic [3:0] C = 4'd0;
  logic       Cout0 = 1'b0;
  logic       Cout1 = 1'b0;
  logic       BLANK = 1'b0;
  logic [3:0] AN;
  logic [6:0] SEG;

  int vectors = 0;
  int miscompares = 0;

  disp_scan #(.DIV_W(DIV_W), .GUARD(GUARD)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .LOAD  (LOAD),
    .B     (B),
    .C     (C),
    .Cout0 (Cout0),
    .Cout1 (Cout1),
    .BLANK (BLANK),
    .AN    (AN),
    .SEG   (SEG)
  );

  always #5 CLK = ~CLK;

  // Glyph table written straight from the decode list
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000;
`ifdef DISP_HEX_EN
    t[10] = 7'b0001000; t[11] = 7'b0000011; t[12] = 7'b1000110;
    t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
`else
    for (int i = 10; i < 16; i++) t[i] = 7'b0111111;
`endif
    return t[n];
  endfunction

  // Model: edgesSinceReset gives the counter phase and the digit slot
  // directly; outputs after an edge depend on the values before it.
  int         edgesSinceReset = 0;
  logic [3:0] mB = 4'd0, mC = 4'd0;
  logic       m0 = 1'b0, m1 = 1'b0;
  logic [3:0] expAn;
  logic [6:0] expSeg;
  bit         modelValid = 1'b0;

  always @(posedge CLK) begin
    int phase, digit;
    logic [3:0] nib, oneHot;
    if (RST) begin
      expAn = 4'hF;
      expSeg = 7'h7F;
      edgesSinceReset = 0;
      mB = 4'd0; mC = 4'd0; m0 = 1'b0; m1 = 1'b0;
    end else begin
      phase = edgesSinceReset % SLOT;
      digit = (edgesSinceReset / SLOT) % 4;
      case (digit)
        0: nib = mB;
        1: nib = {3'b000, m0};
        2: nib = mC;
        default: nib = {3'b000, m1};
      endcase
      oneHot = 4'b0001 << digit;
      expAn = (BLANK || phase < GUARD) ? 4'hF : ~oneHot;
      expSeg = glyph(nib);
      edgesSinceReset++;
      if (LOAD) begin
        mB = B; mC = C; m0 = Cout0; m1 = Cout1;
      end
    end
    modelValid = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (modelValid) begin
      vectors += 2;
      if (AN !== expAn) begin
        miscompares++;
        $display("[TB] FAIL model_an t=%0t: got %b expected %b", $time, AN, expAn);
      end
      if (SEG !== expSeg) begin
        miscompares++;
        $display("[TB] FAIL model_seg t=%0t: got %b expected %b", $time, SEG, expSeg);
      end
    end
  end

  // One clock cycle: drive inputs at the falling edge, return just after
  // the following rising edge so registered outputs can be inspected.
  task automatic applyStimulus(input logic rst, input logic load,
                               input logic [3:0] b, input logic [3:0] c,
                               input logic c0, input logic c1,
                               input logic blank);
    @(negedge CLK);
    RST = rst; LOAD = load; B = b; C = c; Cout0 = c0; Cout1 = c1; BLANK = blank;
    @(posedge CLK);
    #1;
  endtask

  task automatic runIdle(input int n, input logic blank);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, blank);
  endtask

  task automatic checkOutput(input string name, input logic [6:0] actual,
                             input logic [6:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  initial begin
    int an1110, anOff;
    logic [6:0] invGlyph;
`ifdef DISP_HEX_EN
    invGlyph = 7'b1000110;
`else
    invGlyph = 7'b0111111;
`endif

    // Reset held for several cycles
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_an", {3'b000, AN}, 7'b0001111);
    checkOutput("reset_seg", SEG, 7'b1111111);

    // Release: guard for two edges, digit 0 showing captured zero at edge 3
    runIdle(2, 1'b0);
    checkOutput("release_guard_an", {3'b000, AN}, 7'b0001111);
    runIdle(1, 1'b0);
    checkOutput("release_an", {3'b000, AN}, 7'b0001110);
    checkOutput("release_seg", SEG, 7'b1000000);

    // Scan sequence with B=5, C=9, Cout0=1, Cout1=0
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
    runIdle(1, 1'b0);
    checkOutput("scan_d0_an", {3'b000, AN}, 7'b0001110);
    checkOutput("scan_d0_seg", SEG, 7'b0010010);
    runIdle(13, 1'b0);
    checkOutput("scan_guard_an", {3'b000, AN}, 7'b0001111);
    runIdle(1, 1'b0);
    checkOutput("scan_d1_an", {3'b000, AN}, 7'b0001101);
    checkOutput("scan_d1_seg", SEG, 7'b1111001);
    runIdle(16, 1'b0);
    checkOutput("scan_d2_an", {3'b000, AN}, 7'b0001011);
    checkOutput("scan_d2_seg", SEG, 7'b0010000);
    runIdle(16, 1'b0);
    checkOutput("scan_d3_an", {3'b000, AN}, 7'b0000111);
    checkOutput("scan_d3_seg", SEG, 7'b1000000);

    // One full frame: digit 0 active 14 cycles, 8 guard cycles in total
    an1110 = 0;
    anOff = 0;
    for (int i = 0; i < 4 * SLOT; i++) begin
      runIdle(1, 1'b0);
      if (AN === 4'b1110) an1110++;
      if (AN === 4'b1111) anOff++;
    end
    checkOutput("frame_d0_cycles", 7'(an1110), 7'd14);
    checkOutput("frame_guard_cycles", 7'(anOff), 7'd8);

    // Invalid BCD code on digit 0
    applyStimulus(1'b0, 1'b1, 4'b1100, 4'd9, 1'b1, 1'b0, 1'b0);
    runIdle(15, 1'b0);
    checkOutput("invalid_an", {3'b000, AN}, 7'b0001110);
    checkOutput("invalid_seg", SEG, invGlyph);

    // BLANK raised mid digit 1, held 20 cycles, released in digit 2
    runIdle(19, 1'b0);
    checkOutput("blank_pre_an", {3'b000, AN}, 7'b0001101);
    runIdle(1, 1'b1);
    checkOutput("blank_an", {3'b000, AN}, 7'b0001111);
    runIdle(19, 1'b1);
    checkOutput("blank_hold_an", {3'b000, AN}, 7'b0001111);
    runIdle(1, 1'b0);
    checkOutput("blank_release_an", {3'b000, AN}, 7'b0001011);
    checkOutput("blank_release_seg", SEG, 7'b0010000);

    // LOAD on the S1->S2 tick edge; C=3 captured earlier during S0
    runIdle(24, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1100, 4'd3, 1'b1, 1'b0, 1'b0);
    runIdle(27, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1100, 4'd7, 1'b1, 1'b0, 1'b0);
    runIdle(2, 1'b0);
    checkOutput("tickload_guard_an", {3'b000, AN}, 7'b0001111);
    runIdle(1, 1'b0);
    checkOutput("tickload_an", {3'b000, AN}, 7'b0001011);
    checkOutput("tickload_seg", SEG, 7'b1111000);

    // Reset in the middle of digit 2
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("midreset_an", {3'b000, AN}, 7'b0001111);
    checkOutput("midreset_seg", SEG, 7'b1111111);
    runIdle(3, 1'b0);
    checkOutput("midreset_d0_an", {3'b000, AN}, 7'b0001110);
    checkOutput("midreset_d0_seg", SEG, 7'b1000000);
    runIdle(32, 1'b0);
    checkOutput("midreset_d2_an", {3'b000, AN}, 7'b0001011);
    checkOutput("midreset_d2_seg", SEG, 7'b1000000);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) == 0));
    end

    runIdle(2, 1'b0);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
